// File: rtl/mat_mult_ctrl_if.sv
// ----------------------------------------------------------------------------
// mat_mult_ctrl_if
//
// Purpose: groups the host-side handshake of the mat_mult sequencer into one
// bundle. The host register block is the master. The sequencer
// (mat_mult_ctrl) is the slave.
//
// Signals:
//   start   master->slave  job request, accepted only while the sequencer idles
//   mode    master->slave  0 = parallel multiply, 1 = matrix multiply
//   hold    master->slave  stall; only has an effect while a job is running
//   busy    slave->master  high from the cycle after an accepted start through DONE
//   done    slave->master  one-cycle pulse; result is valid from this cycle on
//   err     slave->master  sticky flag for a start issued while busy
//   result  slave->master  captured N x N result array
//   cycles  slave->master  run-phase cycle count of the last job (saturating)
//
// Parameters N, W and CW must match the parameters of the attached sequencer.
// ----------------------------------------------------------------------------
interface mat_mult_ctrl_if #(
  parameter int N  = 2,
  parameter int W  = 27,
  parameter int CW = 16
) ();

  logic                        start;
  logic                        mode;
  logic                        hold;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic [N-1:0][N-1:0][W-1:0]  result;
  logic [CW-1:0]               cycles;

  modport master (
    output start, mode, hold,
    input  busy, done, err, result, cycles
  );

  modport slave (
    input  start, mode, hold,
    output busy, done, err, result, cycles
  );

endinterface : mat_mult_ctrl_if

// File: rtl/mat_mult_ctrl.sv
// ----------------------------------------------------------------------------
// mat_mult_ctrl
//
// Purpose: sequencer for the mat_mult datapath. On an accepted start it clears
// the datapath for one cycle. It then enables the datapath for a fixed,
// mode-dependent number of non-stalled cycles, captures the result array and
// pulses done. It is the only driver of the datapath's reset, enable and mode
// inputs.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous, active-high reset
//   host         if   host handshake (start/mode/hold in; busy/done/err/
//                     result/cycles out), slave side
//   mm_rst       out  datapath reset: rst, or the single clear cycle
//   mm_en        out  datapath enable: run phase and not held
//   mm_mat_mode  out  job mode latched at start; held between jobs
//   mm_result    in   datapath result array [N-1:0][N-1:0][W-1:0]
// ----------------------------------------------------------------------------
module mat_mult_ctrl #(
  parameter int N       = 2,
  parameter int W       = 27,
  parameter int MAT_CYC = 4,
  parameter int PAR_CYC = 3,
  parameter int CW      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  mat_mult_ctrl_if.slave             host,
  output logic                       mm_rst,
  output logic                       mm_en,
  output logic                       mm_mat_mode,
  input  logic [N-1:0][N-1:0][W-1:0] mm_result
);

  localparam int MAX_CYC = (MAT_CYC > PAR_CYC) ? MAT_CYC : PAR_CYC;
  localparam int RW      = $clog2(MAX_CYC + 1);

  localparam logic [RW-1:0] MAT_LOAD = RW'(MAT_CYC);
  localparam logic [RW-1:0] PAR_LOAD = RW'(PAR_CYC);
  localparam logic [RW-1:0] REM_LAST = RW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_CAP,
    S_DONE
  } state_t;

  state_t                     state_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       err_q;
  logic                       clr_q;       // high exactly while in S_CLR
  logic                       run_q;       // high exactly while in S_RUN
  logic                       mat_mode_q;
  logic [RW-1:0]              rem_q;       // enabled cycles still owed to the job
  logic [N-1:0][N-1:0][W-1:0] result_q;
  logic [CW-1:0]              cycles_q;
  logic [CW-1:0]              cycles_d;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;

  // NOTE: all state below uses non-blocking assignments. Every register then
  // samples the pre-edge value of every other register, whatever the
  // statement order.
  // NOTE: result_q is reset even though it is a wide data register. A reset
  // must leave result all-zero, and a mid-job reset must never expose a
  // partial capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clr_q      <= 1'b0;
      run_q      <= 1'b0;
      mat_mode_q <= 1'b0;
      rem_q      <= '0;
      result_q   <= '0;
      cycles_q   <= '0;
    end else begin
      done_q <= 1'b0;
      clr_q  <= 1'b0;

      // A start is rejected outside IDLE. The final DONE cycle counts as
      // outside IDLE. The IDLE branch below clears err on acceptance.
      if (host.start && (state_q != S_IDLE)) begin
        err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (host.start) begin
            mat_mode_q <= host.mode;
            rem_q      <= host.mode ? MAT_LOAD : PAR_LOAD;
            cycles_q   <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            clr_q      <= 1'b1;
            state_q    <= S_CLR;
          end
        end

        S_CLR: begin
          run_q   <= 1'b1;
          state_q <= S_RUN;
        end

        S_RUN: begin
          // The counter advances on stalled cycles too.
          cycles_q <= cycles_d;
          if (!host.hold) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == REM_LAST) begin
              run_q   <= 1'b0;
              state_q <= S_CAP;
            end
          end
        end

        S_CAP: begin
          result_q <= mm_result;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          run_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The enable follows hold in the same cycle, so it cannot be registered.
  // It is gated by run_q, which is never high together with clr_q.
  assign mm_en       = run_q & ~host.hold;
  assign mm_rst      = rst | clr_q;
  assign mm_mat_mode = mat_mode_q;

  assign host.busy   = busy_q;
  assign host.done   = done_q;
  assign host.err    = err_q;
  assign host.result = result_q;
  assign host.cycles = cycles_q;

endmodule : mat_mult_ctrl
